// File: rtl/matrix_screen_ctrl.sv
// matrix_screen_ctrl
//   LED-matrix screen controller for game screens (start / end / score).
//   A double-buffered ROWS x COLS frame store is written row by row into the
//   back buffer; the front buffer is scanned one row per enabled clock onto
//   the active-low row pins (dinor) and the column pins (outc). Back/front
//   roles exchange only when the scan wraps from the last row to row 0, so a
//   displayed frame is never torn.
//
//   Modes: 0 static, 1 blink, 2 horizontal marquee scroll, 3 blank.
//   Build option: define MATRIX_SCROLL_EN to build the scroll rotator and its
//   counters. Without it, mode 2 displays exactly like mode 0.
//
// Ports
//   clk         in   1     scan clock
//   rst         in   1     asynchronous, active-high reset
//   enable      in   1     block active; low holds all counters, matrix dark
//   mode        in   2     display mode (see above)
//   wr_en       in   1     write wr_data into back-buffer row wr_row
//   wr_row      in   RW    back-buffer row address (>= ROWS is ignored)
//   wr_data     in   COLS  row pixels, bit COLS-1 is the leftmost column
//   swap_req    in   1     request a buffer swap at the next frame boundary
//   swap_done   out  1     one-cycle pulse: swap performed
//   frame_start out  1     one-cycle pulse: row 0 is being driven
//   dinor       out  ROWS  row select, active-low, one-hot-zero
//   outc        out  COLS  column data for the selected row
module matrix_screen_ctrl #(
  parameter int ROWS         = 8,
  parameter int COLS         = 16,
  parameter int BLINK_TICKS  = 5000,
  parameter int SCROLL_TICKS = 2500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    swap_req,
  output logic                    swap_done,
  output logic                    frame_start,
  output logic [ROWS-1:0]         dinor,
  output logic [COLS-1:0]         outc
);

  localparam int RW = $clog2(ROWS);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  localparam logic [RW-1:0]   ROW_LAST     = RW'(ROWS - 1);
  localparam logic [RW-1:0]   ROW_ONE      = RW'(1);
  localparam logic [RW-1:0]   ROW_ZERO     = RW'(0);
  localparam logic [RW:0]     ROWS_LIMIT   = (RW + 1)'(ROWS);
  localparam logic [BW-1:0]   BLINK_LAST   = BW'(BLINK_TICKS - 1);
  localparam logic [BW-1:0]   BLINK_ONE    = BW'(1);
  localparam logic [BW-1:0]   BLINK_ZERO   = BW'(0);
  localparam logic [ROWS-1:0] ROW_SEL_BASE = ROWS'(1);
  localparam logic [ROWS-1:0] ROWS_OFF     = {ROWS{1'b1}};
  localparam logic [COLS-1:0] DARK         = {COLS{1'b0}};

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_SCROLL = 2'd2;
  localparam logic [1:0] MODE_BLANK  = 2'd3;

  // Elaboration-time sanity check of the geometry and timing parameters.
  if (ROWS < 2 || COLS < 2 || BLINK_TICKS < 1 || SCROLL_TICKS < 1) begin : g_param_check
    $error("matrix_screen_ctrl: ROWS/COLS must be >= 2 and tick counts >= 1");
  end

  // front_sel_r selects which physical buffer is on screen (0: buf0, 1: buf1).
  logic [COLS-1:0] buf0_r [ROWS];
  logic [COLS-1:0] buf1_r [ROWS];
  logic            front_sel_r;
  logic            swap_pend_r;
  logic [RW-1:0]   row_idx_r;
  logic [BW-1:0]   blink_cnt_r;
  logic            blink_vis_r;

  logic [RW-1:0]   row_next_s;
  logic            swap_now_s;
  logic            swap_pend_next_s;
  logic [BW-1:0]   blink_cnt_next_s;
  logic            blink_vis_next_s;
  logic            wr_ok_s;
  logic [COLS-1:0] front_row_s;
  logic [COLS-1:0] pixel_s;

`ifdef MATRIX_SCROLL_EN
  localparam int SW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
  localparam int OW = $clog2(COLS);
  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_TICKS - 1);
  localparam logic [SW-1:0] SCROLL_ONE  = SW'(1);
  localparam logic [SW-1:0] SCROLL_ZERO = SW'(0);
  localparam logic [OW-1:0] OFF_LAST    = OW'(COLS - 1);
  localparam logic [OW-1:0] OFF_ONE     = OW'(1);
  localparam logic [OW-1:0] OFF_ZERO    = OW'(0);

  logic [SW-1:0] scroll_cnt_r;
  logic [OW-1:0] scroll_off_r;
  logic [SW-1:0] scroll_cnt_next_s;
  logic [OW-1:0] scroll_off_next_s;

  // Rotate left: the doubled word shifted left leaves the rotation in its top half.
  function automatic logic [COLS-1:0] rotl(input logic [COLS-1:0] data, input logic [OW-1:0] amt);
    logic [2*COLS-1:0] dbl;
    dbl = {data, data} << amt;
    return dbl[2*COLS-1:COLS];
  endfunction

  // Scroll timer: advance one column every SCROLL_TICKS enabled cycles in mode 2.
  always_comb begin
    scroll_cnt_next_s = scroll_cnt_r;
    scroll_off_next_s = scroll_off_r;
    if (mode != MODE_SCROLL) begin
      scroll_cnt_next_s = SCROLL_ZERO;
      scroll_off_next_s = OFF_ZERO;
    end else if (enable) begin
      if (scroll_cnt_r == SCROLL_LAST) begin
        scroll_cnt_next_s = SCROLL_ZERO;
        scroll_off_next_s = (scroll_off_r == OFF_LAST) ? OFF_ZERO : scroll_off_r + OFF_ONE;
      end else begin
        scroll_cnt_next_s = scroll_cnt_r + SCROLL_ONE;
      end
    end else begin
      scroll_cnt_next_s = scroll_cnt_r;
    end
  end

  // Scroll timer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scroll_cnt_r <= SCROLL_ZERO;
      scroll_off_r <= OFF_ZERO;
    end else begin
      scroll_cnt_r <= scroll_cnt_next_s;
      scroll_off_r <= scroll_off_next_s;
    end
  end
`endif

  // Next-state for scan position, blink timer and swap handshake.
  always_comb begin
    row_next_s       = row_idx_r;
    swap_now_s       = 1'b0;
    blink_cnt_next_s = blink_cnt_r;
    blink_vis_next_s = blink_vis_r;
    if (enable) begin
      if (row_idx_r == ROW_LAST) begin
        row_next_s = ROW_ZERO;
        swap_now_s = swap_pend_r;
      end else begin
        row_next_s = row_idx_r + ROW_ONE;
      end
    end else begin
      row_next_s = row_idx_r;
    end
    // Outside blink mode the timer is parked so blink always starts visible.
    if (mode != MODE_BLINK) begin
      blink_cnt_next_s = BLINK_ZERO;
      blink_vis_next_s = 1'b1;
    end else if (enable) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_next_s = BLINK_ZERO;
        blink_vis_next_s = ~blink_vis_r;
      end else begin
        blink_cnt_next_s = blink_cnt_r + BLINK_ONE;
      end
    end else begin
      blink_cnt_next_s = blink_cnt_r;
    end
    // A request coinciding with the swap itself is absorbed by that swap.
    swap_pend_next_s = swap_now_s ? 1'b0 : (swap_pend_r | swap_req);
    wr_ok_s          = ({1'b0, wr_row} < ROWS_LIMIT);
  end

  // Pixel data for the row being scanned, per display mode.
  always_comb begin
    front_row_s = DARK;
    pixel_s     = DARK;
    if (front_sel_r) begin
      front_row_s = buf1_r[row_idx_r];
    end else begin
      front_row_s = buf0_r[row_idx_r];
    end
    case (mode)
      MODE_STATIC: pixel_s = front_row_s;
      MODE_BLINK:  pixel_s = blink_vis_r ? front_row_s : DARK;
`ifdef MATRIX_SCROLL_EN
      MODE_SCROLL: pixel_s = rotl(front_row_s, scroll_off_r);
`else
      MODE_SCROLL: pixel_s = front_row_s;
`endif
      MODE_BLANK:  pixel_s = DARK;
      default:     pixel_s = DARK;
    endcase
  end

  // Scan position, blink timer, swap request and buffer-role registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_idx_r   <= ROW_ZERO;
      blink_cnt_r <= BLINK_ZERO;
      blink_vis_r <= 1'b1;
      swap_pend_r <= 1'b0;
      front_sel_r <= 1'b0;
    end else begin
      row_idx_r   <= row_next_s;
      blink_cnt_r <= blink_cnt_next_s;
      blink_vis_r <= blink_vis_next_s;
      swap_pend_r <= swap_pend_next_s;
      front_sel_r <= front_sel_r ^ swap_now_s;
    end
  end

  // Frame store: writes always target the current back buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        buf0_r[r] <= DARK;
        buf1_r[r] <= DARK;
      end
    end else if (wr_en && wr_ok_s) begin
      if (front_sel_r) begin
        buf0_r[wr_row] <= wr_data;
      end else begin
        buf1_r[wr_row] <= wr_data;
      end
    end
  end

  // Registered pin drivers, one cycle behind the scan position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dinor       <= ROWS_OFF;
      outc        <= DARK;
      frame_start <= 1'b0;
      swap_done   <= 1'b0;
    end else if (enable) begin
      dinor       <= ~(ROW_SEL_BASE << row_idx_r);
      outc        <= pixel_s;
      frame_start <= (row_idx_r == ROW_ZERO);
      swap_done   <= swap_now_s;
    end else begin
      dinor       <= ROWS_OFF;
      outc        <= DARK;
      frame_start <= 1'b0;
      swap_done   <= 1'b0;
    end
  end

endmodule
